// File: rtl/therm_frame_tx.sv
// therm_frame_tx: frames one 8-bit ring-oscillator sample per window into a
// 4-byte UART frame {SYNC_BYTE, seq, sample, checksum} and hands the bytes to
// the UART over a start/busy handshake.
//   clk, rst          : clock, synchronous active-high reset
//   sample_valid      : one-cycle strobe qualifying sample
//   sample[7:0]       : latched oscillator count
//   uart_busy         : UART transmitter busy
//   uart_start        : request UART to send uart_data (held until busy seen)
//   uart_data[7:0]    : byte being offered; stable while uart_start is high
//   frame_busy        : frame in progress
//   frame_done        : pulse when the last byte has left the UART
//   drop_cnt[7:0]     : saturating count of overwritten samples
//   err_timeout       : sticky, UART never acknowledged a start
module therm_frame_tx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       uart_busy,
  output logic       uart_start,
  output logic [7:0] uart_data,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(ACK_TIMEOUT);

  state_t      state, state_nx;
  logic        pend_valid, pend_valid_nx;
  logic [7:0]  pend_data, pend_data_nx;
  logic [7:0]  seq, seq_nx;
  logic [7:0]  frm_seq, frm_seq_nx;
  logic [7:0]  frm_data, frm_data_nx;
  logic [1:0]  idx, idx_nx, idx_inc;
  logic [15:0] tmo_cnt, tmo_cnt_nx;
  logic        uart_start_nx;
  logic [7:0]  uart_data_nx;
  logic        frame_done_nx;
  logic [7:0]  drop_cnt_nx;
  logic        err_timeout_nx;
  logic        consume;
  logic [7:0]  next_byte;

  assign idx_inc = idx + 2'd1;

  // Checksum is rebuilt from the stored frame fields rather than kept as a
  // separate register.
  always_comb begin
    case (idx_inc)
      2'd1:    next_byte = frm_seq;
      2'd2:    next_byte = frm_data;
      2'd3:    next_byte = SYNC_BYTE ^ frm_seq ^ frm_data;
      default: next_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_nx       = state;
    pend_valid_nx  = pend_valid;
    pend_data_nx   = pend_data;
    seq_nx         = seq;
    frm_seq_nx     = frm_seq;
    frm_data_nx    = frm_data;
    idx_nx         = idx;
    tmo_cnt_nx     = tmo_cnt;
    uart_start_nx  = uart_start;
    uart_data_nx   = uart_data;
    frame_done_nx  = 1'b0;
    drop_cnt_nx    = drop_cnt;
    err_timeout_nx = err_timeout;
    consume        = (state == IDLE) && pend_valid;

    case (state)
      IDLE: begin
        if (pend_valid) begin
          frm_seq_nx    = seq;
          frm_data_nx   = pend_data;
          seq_nx        = seq + 8'd1;
          idx_nx        = '0;
          tmo_cnt_nx    = '0;
          uart_start_nx = 1'b1;
          uart_data_nx  = SYNC_BYTE;
          state_nx      = REQ;
        end
      end
      REQ: begin
        if (uart_busy) begin
          uart_start_nx = 1'b0;
          state_nx      = WAIT;
        end else begin
          tmo_cnt_nx = tmo_cnt + 16'd1;
          if (tmo_cnt + 16'd1 == TMO_LIMIT) begin
            uart_start_nx  = 1'b0;
            err_timeout_nx = 1'b1;
            state_nx       = IDLE;
          end
        end
      end
      WAIT: begin
        if (!uart_busy) begin
          if (idx == 2'd3) begin
            frame_done_nx = 1'b1;
            state_nx      = IDLE;
          end else begin
            state_nx = NEXT;
          end
        end
      end
      NEXT: begin
        idx_nx        = idx_inc;
        uart_data_nx  = next_byte;
        uart_start_nx = 1'b1;
        tmo_cnt_nx    = '0;
        state_nx      = REQ;
      end
      default: state_nx = IDLE;
    endcase

    // A sample arriving on the consuming edge refills the buffer without loss.
    if (sample_valid) begin
      pend_data_nx  = sample;
      pend_valid_nx = 1'b1;
      if (pend_valid && !consume && drop_cnt != 8'hFF)
        drop_cnt_nx = drop_cnt + 8'd1;
    end else if (consume) begin
      pend_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      seq         <= '0;
      frm_seq     <= '0;
      frm_data    <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      drop_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_valid  <= pend_valid_nx;
      pend_data   <= pend_data_nx;
      seq         <= seq_nx;
      frm_seq     <= frm_seq_nx;
      frm_data    <= frm_data_nx;
      idx         <= idx_nx;
      tmo_cnt     <= tmo_cnt_nx;
      uart_start  <= uart_start_nx;
      uart_data   <= uart_data_nx;
      frame_busy  <= (state_nx != IDLE);
      frame_done  <= frame_done_nx;
      drop_cnt    <= drop_cnt_nx;
      err_timeout <= err_timeout_nx;
    end
  end

endmodule

// File: tb/tb_therm_frame_tx.sv
// Bench for therm_frame_tx: a frame-queue reference model predicts every
// output each cycle; directed scenarios pin literal frame bytes and counters.
module tb_therm_frame_tx;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic       uart_busy;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       frame_busy;
  logic       frame_done;
  logic [7:0] drop_cnt;
  logic       err_timeout;

  therm_frame_tx #(
    .SYNC_BYTE  (8'hA5),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .uart_busy   (uart_busy),
    .uart_start  (uart_start),
    .uart_data   (uart_data),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .drop_cnt    (drop_cnt),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // reference model: frame held as a queue of bytes still to be offered
  bit         m_inframe = 0, m_start = 0, m_done = 0, m_err = 0, m_pend_v = 0;
  int         m_phase   = 0;   // 0 offering byte, 1 awaiting busy fall, 2 loading next
  int         m_tmo     = 0;
  logic [7:0] m_data = '0, m_pend_d = '0, m_seq = '0, m_drop = '0;
  logic [7:0] m_left[$];

  // UART environment
  int u_dly = 2, u_hold = 10, u_cnt = 0;
  bit u_active = 0;

  logic [7:0] sent[$];
  logic [7:0] expq[$];
  int n_done = 0;

  task automatic model_step();
    bit consume;
    if (rst) begin
      m_inframe = 0; m_start = 0; m_done = 0; m_err = 0; m_pend_v = 0;
      m_data = '0; m_pend_d = '0; m_seq = '0; m_drop = '0; m_tmo = 0; m_phase = 0;
      m_left.delete();
      return;
    end
    consume = !m_inframe && m_pend_v;
    m_done  = 0;
    if (!m_inframe) begin
      if (m_pend_v) begin
        m_left    = '{m_seq, m_pend_d, 8'hA5 ^ m_seq ^ m_pend_d};
        m_data    = 8'hA5;
        m_start   = 1;
        m_inframe = 1;
        m_phase   = 0;
        m_tmo     = 0;
        m_seq     = m_seq + 8'd1;
      end
    end else if (m_phase == 0) begin
      if (uart_busy) begin
        m_start = 0;
        m_phase = 1;
      end else begin
        m_tmo++;
        if (m_tmo == TMO) begin
          m_start = 0; m_err = 1; m_inframe = 0;
          m_left.delete();
        end
      end
    end else if (m_phase == 1) begin
      if (!uart_busy) begin
        if (m_left.size() == 0) begin
          m_done = 1; m_inframe = 0;
        end else begin
          m_phase = 2;
        end
      end
    end else begin
      m_data  = m_left.pop_front();
      m_start = 1; m_tmo = 0; m_phase = 0;
    end
    if (sample_valid) begin
      if (m_pend_v && !consume && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      m_pend_d = sample;
      m_pend_v = 1;
    end else if (consume) begin
      m_pend_v = 0;
    end
  endtask

  task automatic uart_step();
    if (!u_active) begin
      if (uart_start === 1'b1) begin
        u_cnt++;
        if (u_cnt >= u_dly) begin uart_busy = 1'b1; u_active = 1; u_cnt = 0; end
      end else begin
        u_cnt = 0;
      end
    end else begin
      u_cnt++;
      if (u_cnt >= u_hold) begin uart_busy = 1'b0; u_active = 0; u_cnt = 0; end
    end
  endtask

  task automatic cycle();
    if (!rst && uart_start === 1'b1 && uart_busy) sent.push_back(uart_data);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (frame_done === 1'b1) n_done++;
    n_vec++;
    if ({uart_start, uart_data, frame_busy, frame_done, drop_cnt, err_timeout} !==
        {m_start, m_data, m_inframe, m_done, m_drop, m_err}) begin
      n_miss++;
      $display("FAIL cycle %0d outputs: got start=%0b data=%02h busy=%0b done=%0b drop=%0d err=%0b, expected start=%0b data=%02h busy=%0b done=%0b drop=%0d err=%0b",
               cyc, uart_start, uart_data, frame_busy, frame_done, drop_cnt, err_timeout,
               m_start, m_data, m_inframe, m_done, m_drop, m_err);
    end
    if (rst) begin
      uart_busy = 1'b0; u_active = 0; u_cnt = 0;
    end else begin
      uart_step();
    end
    rst          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse(input logic [7:0] v);
    sample_valid = 1'b1;
    sample       = v;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    sent.delete();
    n_done = 0;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic check_sent(input string name);
    logic [7:0] g;
    check8({name, " count"}, 8'(sent.size()), 8'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      g = (i < sent.size()) ? sent[i] : 8'hxx;
      check8($sformatf("%s byte%0d", name, i), g, expq[i]);
    end
  endtask

  task automatic wait_done(input int budget, input string what);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (frame_done !== 1'b1 && k < budget);
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_miss++;
      $display("FAIL %s wait: frame_done got 0 expected 1 within %0d cycles", what, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int k;
    logic [7:0] v;

    rst = 1'b1; sample_valid = 1'b0; sample = '0; uart_busy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check8("reset start", 8'(uart_start), 8'h00);
    check8("reset data", uart_data, 8'h00);
    check8("reset frame_busy", 8'(frame_busy), 8'h00);
    check8("reset done", 8'(frame_done), 8'h00);
    check8("reset drop", drop_cnt, 8'h00);
    check8("reset err", 8'(err_timeout), 8'h00);

    // single sample, latency and frame contents
    do_reset();
    u_dly = 2; u_hold = 10;
    pulse(8'h3C);
    check8("latency edge k", 8'(uart_start), 8'h00);
    cycle();
    check8("latency edge k+1", 8'(uart_start), 8'h01);
    wait_done(400, "single");
    idle(3);
    expq = '{8'hA5, 8'h00, 8'h3C, 8'h99};
    check_sent("single frame");
    check8("single done count", 8'(n_done), 8'd1);
    check8("single drop", drop_cnt, 8'h00);

    // three frames then sequence wrap
    do_reset();
    pulse(8'h11); wait_done(400, "f11");
    pulse(8'h22); wait_done(400, "f22");
    pulse(8'h33); wait_done(400, "f33");
    expq = '{8'hA5, 8'h00, 8'h11, 8'hB4, 8'hA5, 8'h01, 8'h22, 8'h86,
             8'hA5, 8'h02, 8'h33, 8'h94};
    check_sent("three frames");
    u_dly = 1; u_hold = 1;
    for (int i = 3; i < 256; i++) begin
      pulse(8'($urandom));
      wait_done(100, "fill seq");
    end
    sent.delete();
    v = 8'($urandom);
    pulse(v);
    wait_done(100, "seq wrap");
    expq = '{8'hA5, 8'h00, v, 8'hA5 ^ v};
    check_sent("seq wrap frame");

    // overrun and same-edge consume/capture
    do_reset();
    u_dly = 2; u_hold = 10;
    pulse(8'h10); idle(4);
    pulse(8'h20); idle(4);
    pulse(8'h30);
    check8("overrun drop", drop_cnt, 8'd1);
    wait_done(400, "ov f1");
    pulse(8'h44);               // lands on the edge that consumes 8'h30
    check8("same-edge drop", drop_cnt, 8'd1);
    wait_done(400, "ov f2");
    wait_done(400, "ov f3");
    expq = '{8'hA5, 8'h00, 8'h10, 8'hB5, 8'hA5, 8'h01, 8'h30, 8'h94,
             8'hA5, 8'h02, 8'h44, 8'hE3};
    check_sent("overrun frames");
    check8("overrun drop final", drop_cnt, 8'd1);

    // UART never acknowledges
    do_reset();
    u_dly = 100000;
    pulse(8'h5A);
    cnt = 0;
    repeat (40) begin
      cycle();
      if (uart_start === 1'b1) cnt++;
    end
    check8("timeout start cycles", 8'(cnt), 8'd16);
    check8("timeout err", 8'(err_timeout), 8'h01);
    check8("timeout no done", 8'(n_done), 8'd0);
    u_dly = 2; u_hold = 3;
    idle(5);
    pulse(8'h77);
    wait_done(400, "after timeout");
    expq = '{8'hA5, 8'h01, 8'h77, 8'hD3};
    check_sent("after timeout frame");
    check8("timeout err sticky", 8'(err_timeout), 8'h01);

    // reset while waiting on byte 2
    do_reset();
    u_dly = 2; u_hold = 3;
    pulse(8'h66); idle(2);
    pulse(8'h99);
    k = 0;
    while (!(sent.size() == 3 && uart_start === 1'b0 && frame_busy === 1'b1) && k < 200) begin
      cycle();
      k++;
    end
    check8("reached byte2 wait", 8'(sent.size()), 8'd3);
    rst = 1'b1;
    cycle();
    check8("midrst start", 8'(uart_start), 8'h00);
    check8("midrst data", uart_data, 8'h00);
    check8("midrst frame_busy", 8'(frame_busy), 8'h00);
    check8("midrst drop", drop_cnt, 8'h00);
    idle(4);
    check8("midrst pending lost", 8'(frame_busy), 8'h00);
    sent.delete();
    pulse(8'h12);
    wait_done(400, "after midrst");
    expq = '{8'hA5, 8'h00, 8'h12, 8'hB7};
    check_sent("after midrst frame");

    // drop counter saturation during a stalled frame
    do_reset();
    u_dly = 1; u_hold = 100000;
    pulse(8'h01);
    idle(5);
    repeat (300) pulse(8'($urandom));
    check8("drop saturate", drop_cnt, 8'd255);
    u_hold = 1;
    wait_done(200, "stall release");
    wait_done(200, "stall pending");
    check8("drop saturate after", drop_cnt, 8'd255);

    // randomized traffic with occasional reset
    do_reset();
    repeat (3000) begin
      if (!u_active && uart_start !== 1'b1) begin
        u_dly  = $urandom_range(1, 4);
        u_hold = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      sample_valid = ($urandom_range(0, 9) == 0);
      sample       = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/therm_frame_tx.md
Name: therm_frame_tx

Overview:
- Framing stage between the window-latched ring-oscillator count and the UART byte transmitter.
- Accepts one 8-bit sample per measurement window and serialises it into a 4-byte frame: sync, sequence, count, checksum.
- Feeds the UART one byte at a time over its start/busy handshake.
- Buffers one sample while a frame is in flight and counts samples dropped on overrun.

Parameters:
- SYNC_BYTE, 8'hA5, constant first byte of every frame.
- ACK_TIMEOUT, 1024, max cycles uart_start may stay high without uart_busy rising (16-bit counter, ≥2).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- sample_valid, input, 1, one-cycle pulse; sample is valid this cycle.
- sample, input, 8, latched count value.
- uart_busy, input, 1, UART transmitter busy.
- uart_start, output, 1, request to UART to send uart_data.
- uart_data, output, 8, byte to transmit; stable while uart_start is high.
- frame_busy, output, 1, high from leaving IDLE until return to IDLE.
- frame_done, output, 1, one-cycle pulse when the last byte's UART busy falls.
- drop_cnt, output, 8, saturating count of overwritten samples.
- err_timeout, output, 1, sticky; UART failed to acknowledge a start.

Behaviour:
- Reset: all outputs 0; state IDLE; pend_valid 0; seq 0; timeout counter 0.
- Reset applied mid-frame aborts the frame: uart_start is low on the cycle after the reset edge, and the pending sample is lost.
- Pending buffer (1 deep):
  - sample_valid high at edge k writes pend_data=sample and sets pend_valid=1.
  - If pend_valid is already 1 and is not being consumed at edge k, the new sample overwrites it and drop_cnt increments, saturating at 255.
  - If IDLE consumes the buffer at the same edge k, the new sample is stored with no drop.
- FSM states: IDLE, REQ, WAIT, NEXT. Byte index idx is 0..3.
- IDLE with pend_valid=1, at the next edge:
  - Load frame: b0=SYNC_BYTE, b1=seq, b2=pend_data, b3=b0^b1^b2.
  - Clear pend_valid, set idx=0, seq<=seq+1 (8-bit wrap, 255->0).
  - Assert uart_start=1 with uart_data=b0 and go to REQ.
  - Latency: sample_valid at edge k in IDLE gives uart_start high after edge k+1.
- REQ: hold uart_start and uart_data.
  - When uart_busy=1 is sampled, drop uart_start at that edge and go to WAIT.
  - The timeout counter increments each REQ cycle. When it reaches ACK_TIMEOUT: uart_start<=0, err_timeout<=1, abandon the frame (no frame_done), go to IDLE.
  - seq is not rolled back on a timeout abort.
- WAIT: when uart_busy=0 is sampled, go to NEXT.
  - If idx=3, pulse frame_done and go to IDLE instead.
- NEXT: idx<=idx+1, uart_data<=b[idx+1], uart_start<=1, clear the timeout counter, go to REQ.
- uart_start is registered and never high in IDLE or WAIT. uart_data changes only on the edge that raises uart_start.
- frame_busy = (state != IDLE), registered alongside the state.
- Back-to-back: if pend_valid=1 when WAIT exits on idx=3, go to IDLE and start the next frame on the following edge. The minimum frame gap is 1 idle cycle.
- uart_busy already high when a frame starts: REQ sees it immediately and proceeds. Sustained misbehaviour is caught by the timeout only.
- sample is sampled only when sample_valid=1.

Test Plan:
- Single sample 8'h3C, UART model with busy 2 cycles after start, held 10 cycles → bytes A5,00,3C,99 in order, uart_start high after edge k+1, one frame_done, drop_cnt=0.
- Three frames, samples 11,22,33 → sequence bytes 00,01,02 and checksums A5^00^11=B4, A5^01^22=86, A5^02^33=94. Also preload seq to 255 by sending 256 frames and check the next seq byte is 00.
- Samples 10,20,30 pulsed 5 cycles apart while frame 1 is in flight → frame 2 carries 30, drop_cnt=1, 20 never sent. Also check the same-edge consume-and-capture case gives drop_cnt unchanged.
- UART model never raises busy, ACK_TIMEOUT=16 → uart_start falls after 16 REQ cycles, err_timeout=1 sticky, no frame_done; a later sample starts a new frame.
- Assert rst during WAIT of byte 2 → after the reset edge all outputs 0 and seq=0; the next sample yields a frame with seq byte 00.
- 300 overruns during a stalled frame → drop_cnt saturates at 255, no wrap.
